// File: rtl/tiny_dnn_pkg.sv
// Shared types and constants for the tiny DNN accelerator blocks.
package tiny_dnn_pkg;

   localparam int ADDR_W     = 13;
   localparam int BANK_DEPTH = 4096;
   localparam int WA_W_DEF   = 16;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      OUT,
      DONE
   } fc_state_t;

endpackage

// File: rtl/tiny_dnn_mac.sv
// Multiply-accumulate datapath: delayed-valid accumulate plus ReLU output register.
module tiny_dnn_mac (
   input  logic clk,
   input  logic rst_n,
   input  logic v,
   input  logic first,
   input  real  d,
   input  real  wd,
   input  logic load_x,
   input  logic relu,
   output real  x
);

   logic v_q;
   logic first_q;
   real  acc;

   // Operands arrive one cycle after the read strobe, so valid/first are delayed to match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= 1'b0;
         first_q <= 1'b0;
         acc     <= 0.0;
         x       <= 0.0;
      end else begin
         v_q     <= v;
         first_q <= first;
         if (v_q)
            acc <= first_q ? d * wd : acc + d * wd;
         if (load_x)
            x <= (relu && acc < 0.0) ? 0.0 : acc;
      end
   end

endmodule

// File: rtl/tiny_dnn_fc_seq.sv
// Fully-connected layer sequencer: walks src/weight reads per neuron and writes each result to dst_buf.
module tiny_dnn_fc_seq
   import tiny_dnn_pkg::*;
#(
   parameter int SRC_DEPTH = BANK_DEPTH,
   parameter int WA_W      = WA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_size,
   input  logic [ADDR_W-1:0] dst_size,
   input  logic              sbank,
   input  logic              dbank,
   input  logic              relu,
   output logic              exec,
   output logic [ADDR_W-1:0] ia,
   input  real               d,
   output logic [WA_W-1:0]   wa,
   input  real               wd,
   output logic              outr,
   output logic [ADDR_W-1:0] oa,
   output real               x,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = $clog2(SRC_DEPTH);

   fc_state_t         state, nxt;
   logic [IDX_W-1:0]  i, o;
   logic [WA_W-1:0]   w;
   logic [ADDR_W-1:0] src_l, dst_l;
   logic              sbank_l, dbank_l, relu_l;
   logic              last_i, last_o;

   assign last_i = ({1'b0, i} == src_l - ADDR_W'(1));
   assign last_o = ({1'b0, o} == dst_l - ADDR_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt  = state;
      exec = 1'b0;
      outr = 1'b0;
      busy = 1'b1;
      done = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               nxt = (src_size == '0 || dst_size == '0) ? DONE : RUN;
         end
         RUN: begin
            exec = 1'b1;
            if (last_i) nxt = DRAIN;
         end
         DRAIN: nxt = OUT;
         OUT: begin
            outr = 1'b1;
            nxt  = last_o ? DONE : RUN;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Config is only captured in IDLE, so a start while busy leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i       <= '0;
         o       <= '0;
         w       <= '0;
         src_l   <= '0;
         dst_l   <= '0;
         sbank_l <= 1'b0;
         dbank_l <= 1'b0;
         relu_l  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               src_l   <= src_size;
               dst_l   <= dst_size;
               sbank_l <= sbank;
               dbank_l <= dbank;
               relu_l  <= relu;
               i       <= '0;
               o       <= '0;
               w       <= '0;
            end
            RUN: begin
               w <= w + 1'b1;
               if (!last_i) i <= i + 1'b1;
            end
            OUT: if (!last_o) begin
               o <= o + 1'b1;
               i <= '0;
            end
            default: ;
         endcase
      end
   end

   assign ia = {sbank_l, i};
   assign oa = {dbank_l, o};
   assign wa = w;

   tiny_dnn_mac u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .v      (exec),
      .first  (exec && i == '0),
      .d      (d),
      .wd     (wd),
      .load_x (state == OUT),
      .relu   (relu_l),
      .x      (x)
   );

endmodule

// File: tb/tb_tiny_dnn_fc_seq.sv
// Scoreboard bench for tiny_dnn_fc_seq with directed layers and hand-computed results.
module tb_tiny_dnn_fc_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [12:0] src_size = '0, dst_size = '0;
   logic        sbank = 1'b0, dbank = 1'b0, relu = 1'b0;
   logic        exec, outr, busy, done;
   logic [12:0] ia, oa;
   logic [15:0] wa;
   real         d = 0.0, wd = 0.0, x;

   tiny_dnn_fc_seq #(.SRC_DEPTH(4096), .WA_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src_size(src_size), .dst_size(dst_size),
      .sbank(sbank), .dbank(dbank), .relu(relu), .exec(exec), .ia(ia), .d(d), .wa(wa),
      .wd(wd), .outr(outr), .oa(oa), .x(x), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [12:0] ia; logic [15:0] wa; } rd_t;
   typedef struct { logic [12:0] oa; real x; } wr_t;
   rd_t rd_q[$];
   wr_t wr_q[$];

   real smem[0:8191];
   real wmem[0:255];
   int  errors = 0, checks = 0, exec_cnt = 0, outr_cnt = 0;

   task automatic chk_int(input string n, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic chk_real(input string n, input real act, input real exp);
      real diff;
      diff = act - exp;
      if (diff < 0.0) diff = -diff;
      checks++;
      if (diff > 1e-9) begin
         errors++;
         $display("FAIL %s: got %f expected %f", n, act, exp);
      end
   endtask

   // Buffer models: return data in the cycle after exec.
   logic        pend = 1'b0;
   logic [12:0] pia = '0;
   logic [15:0] pwa = '0;
   always @(negedge clk) begin
      pend = exec;
      pia  = ia;
      pwa  = wa;
   end
   always @(posedge clk) begin
      #1;
      if (pend) begin
         d  = smem[pia];
         wd = wmem[pwa[7:0]];
      end
   end

   // Monitor: reads compared on exec, writes compared (oa, x) the cycle after outr.
   logic        outr_d = 1'b0;
   logic [12:0] oa_s = '0;
   always @(negedge clk) begin
      rd_t r;
      wr_t e;
      if (!rst_n) begin
         outr_d = 1'b0;
      end else begin
         if (outr_d) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: oa=%0h x=%f, none expected", oa_s, x);
            end else begin
               e = wr_q.pop_front();
               chk_int("write_oa", oa_s, e.oa);
               chk_real("write_x", x, e.x);
            end
         end
         outr_d = outr;
         oa_s   = oa;
         if (outr) outr_cnt++;
         if (exec) begin
            exec_cnt++;
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: ia=%0h wa=%0h, none expected", ia, wa);
            end else begin
               r = rd_q.pop_front();
               chk_int("read_ia", ia, r.ia);
               chk_int("read_wa", wa, r.wa);
            end
         end
      end
   end

   task automatic push_reads(input int src, input int dst, input bit sb);
      rd_t r;
      for (int n = 0; n < dst; n++)
         for (int k = 0; k < src; k++) begin
            r.ia = {sb, 12'(k)};
            r.wa = 16'(n * src + k);
            rd_q.push_back(r);
         end
   endtask

   task automatic push_wr(input logic [12:0] a, input real v);
      wr_t e;
      e.oa = a;
      e.x  = v;
      wr_q.push_back(e);
   endtask

   task automatic start_layer(input int src, input int dst, input bit sb, input bit db, input bit rl);
      @(negedge clk);
      src_size = 13'(src);
      dst_size = 13'(dst);
      sbank = sb; dbank = db; relu = rl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge of cycle S+1; returns at the negedge of the done cycle.
   task automatic wait_done(input int exp, input string n);
      int k;
      k = 1;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk_int(n, done ? k : -1, exp);
   endtask

   task automatic drain(input string n);
      @(negedge clk);
      chk_int({n, "_reads_left"}, rd_q.size(), 0);
      chk_int({n, "_writes_left"}, wr_q.size(), 0);
   endtask

   task automatic load_4x2;
      for (int k = 0; k < 4; k++) begin
         smem[k]     = real'(k + 1);
         wmem[k]     = 1.0;
         wmem[k + 4] = 0.5;
      end
   endtask

   int e0, o0;

   initial begin
      for (int k = 0; k < 8192; k++) smem[k] = 0.0;
      for (int k = 0; k < 256; k++) wmem[k] = 0.0;

      repeat (2) @(negedge clk);
      chk_int("rst_exec", exec, 0);
      chk_int("rst_outr", outr, 0);
      chk_int("rst_busy", busy, 0);
      chk_int("rst_done", done, 0);
      chk_int("rst_ia", ia, 0);
      chk_int("rst_oa", oa, 0);
      chk_int("rst_wa", wa, 0);
      chk_real("rst_x", x, 0.0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single MAC: 2.0 * 3.0 from source bank 1.
      smem[13'h1000] = 2.0;
      wmem[0] = 3.0;
      push_reads(1, 1, 1'b1);
      push_wr(13'h0000, 6.0);
      start_layer(1, 1, 1'b1, 1'b0, 1'b0);
      chk_int("single_first_exec", exec, 1);
      chk_int("single_busy", busy, 1);
      wait_done(4, "single_done_lat");
      drain("single");

      // 4x2 layer into bank 1.
      load_4x2();
      push_reads(4, 2, 1'b0);
      push_wr(13'h1000, 10.0);
      push_wr(13'h1001, 5.0);
      start_layer(4, 2, 1'b0, 1'b1, 1'b0);
      wait_done(13, "l4x2_done_lat");
      drain("l4x2");

      // Dot product of -3.5 with and without ReLU.
      smem[0] = 1.5; smem[1] = -2.5;
      wmem[0] = 1.0; wmem[1] = 2.0;
      push_reads(2, 1, 1'b0);
      push_wr(13'h0000, 0.0);
      start_layer(2, 1, 1'b0, 1'b0, 1'b1);
      wait_done(5, "relu_on_done_lat");
      drain("relu_on");
      push_reads(2, 1, 1'b0);
      push_wr(13'h0000, -3.5);
      start_layer(2, 1, 1'b0, 1'b0, 1'b0);
      wait_done(5, "relu_off_done_lat");
      drain("relu_off");

      // Zero sizes finish immediately with no traffic.
      e0 = exec_cnt; o0 = outr_cnt;
      start_layer(0, 3, 1'b0, 1'b0, 1'b0);
      wait_done(1, "zero_src_done_lat");
      start_layer(5, 0, 1'b1, 1'b1, 1'b0);
      wait_done(1, "zero_dst_done_lat");
      repeat (3) @(negedge clk);
      chk_int("zero_exec_count", exec_cnt, e0);
      chk_int("zero_outr_count", outr_cnt, o0);
      chk_int("zero_busy", busy, 0);

      // Start while busy and start during done are both ignored.
      load_4x2();
      push_reads(4, 2, 1'b0);
      push_wr(13'h1000, 10.0);
      push_wr(13'h1001, 5.0);
      fork
         begin
            start_layer(4, 2, 1'b0, 1'b1, 1'b0);
            wait_done(13, "collide_done_lat");
            src_size = 13'd1; dst_size = 13'd1; sbank = 1'b1; dbank = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk_int("done_cycle_start_busy", busy, 0);
            chk_int("done_cycle_start_exec", exec, 0);
         end
         begin
            repeat (4) @(negedge clk);
            src_size = 13'd1; dst_size = 13'd1; sbank = 1'b1; dbank = 1'b0; relu = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      drain("collide");

      // Reset during RUN of neuron 1 of 3.
      load_4x2();
      push_reads(4, 3, 1'b0);
      push_wr(13'h0000, 10.0);
      start_layer(4, 3, 1'b0, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      chk_int("midrst_busy_before", busy, 1);
      chk_int("midrst_exec_before", exec, 1);
      rst_n = 1'b0;
      #1;
      chk_int("midrst_exec", exec, 0);
      chk_int("midrst_outr", outr, 0);
      chk_int("midrst_busy", busy, 0);
      chk_int("midrst_ia", ia, 0);
      chk_int("midrst_wa", wa, 0);
      chk_int("midrst_oa", oa, 0);
      chk_real("midrst_x", x, 0.0);
      rd_q.delete();
      wr_q.delete();
      o0 = outr_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_int("midrst_no_outr", outr_cnt, o0);
      push_reads(4, 2, 1'b0);
      push_wr(13'h1000, 10.0);
      push_wr(13'h1001, 5.0);
      start_layer(4, 2, 1'b0, 1'b1, 1'b0);
      wait_done(13, "after_rst_done_lat");
      drain("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/tiny_dnn_fc_seq.md
# tiny_dnn_fc_seq

Fully-connected layer sequencer and MAC engine for the MNIST accelerator, sitting between `src_buf` and `dst_buf`. It drives `exec/ia` to `src_buf` and, in lockstep, a weight address to the external weight buffer. It multiply-accumulates the returned `d × wd` values and writes each finished output neuron to `dst_buf` through `outr/oa/x`. It is simulation-level RTL and uses `real` for data, like its neighbours.

## Interface
Parameters:
- `SRC_DEPTH`, default 4096: words per buffer bank; the in-bank index is 12 bits.
- `WA_W`, default 16: weight address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run a layer; ignored while `busy`.
- `src_size`  in  13  inputs per neuron, 0..4096; sampled on accepted `start`.
- `dst_size`  in  13  output neurons, 0..4096; sampled on accepted `start`.
- `sbank`  in  1  source bank, becomes `ia[12]`; sampled on `start`.
- `dbank`  in  1  destination bank, becomes `oa[12]`; sampled on `start`.
- `relu`  in  1  apply max(0,·) to outputs; sampled on `start`.
- `exec`  out  1  source read strobe to `src_buf`.
- `ia`  out  13  source read address, {sbank, index}.
- `d`  in  real  source data, valid the cycle after `exec`.
- `wa`  out  WA_W  weight read address, issued with `exec`.
- `wd`  in  real  weight data, valid the cycle after `exec`.
- `outr`  out  1  output write request to `dst_buf`.
- `oa`  out  13  output address, {dbank, neuron}.
- `x`  out  real  output value, valid the cycle after `outr`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the layer is finished.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: issue reads.
  - DRAIN: last product lands.
  - OUT: write the output.
  - DONE: pulse `done`.
- IDLE → RUN on `start` when both sizes are nonzero. If either size is 0, IDLE → DONE and no `exec` or `outr` is ever issued.
- RUN, one read per cycle:
  - `exec`=1, `ia`={sbank_l, i}, `wa`=w.
  - `i` counts 0..src_size-1; `w` is a running counter cleared on `start` and incremented on every `exec`.
  - After issuing `i`=src_size-1 → DRAIN.
- Accumulate:
  - A one-cycle-delayed `exec` flag gates `acc <= first ? d*wd : acc + d*wd`.
  - `first` marks the product of `i`=0, so `acc` clears per neuron without a dedicated cycle.
- DRAIN: `exec`=0; the last product is accumulated at the end of this cycle. DRAIN → OUT.
- OUT:
  - `outr`=1, `oa`={dbank_l, o}.
  - Register `x` loads `relu_l ? max(acc,0.0) : acc` at the end of this cycle; `x` holds until the next OUT.
  - If `o`==dst_size-1 → DONE; otherwise `o`++, `i`=0, → RUN.
- DONE: `done`=1 for one cycle → IDLE.
- `wa` wraps modulo 2^WA_W. The caller guarantees src_size·dst_size ≤ 2^WA_W; the block does not check this.

## Timing
- Reset values (async, `rst_n`=0):
  - state IDLE; `exec`, `outr`, `busy`, `done` = 0.
  - `ia`, `oa`, `wa` = 0; `acc`, `x` = 0.0; all latched config = 0.
- Reset mid-layer aborts immediately, with no further writes. `dst_buf` may still complete one write already registered by it.
- Latency from the `start` cycle S:
  - First `exec` at S+1.
  - Per neuron: src_size RUN cycles, then 1 DRAIN, then 1 OUT.
  - First `outr` at S+src_size+2.
  - `done` at S+1+dst_size·(src_size+2).
  - Zero-size `start`: `done` at S+1.
- The `outr` → `x` relation matches `dst_buf`, which registers `outr/oa` and writes `x` one cycle later. `x` is stable during the cycle after `outr`.
- `acc` is not overwritten before the next neuron's first product, which lands 2 cycles after OUT.
- `start` while `busy` is ignored, with no effect on the latched config.
- `start` in the same cycle as `done` is ignored. `start` is accepted only in IDLE.

## Structure
- Shared package `tiny_dnn_pkg`:
  - `typedef enum` for the states: IDLE, RUN, DRAIN, OUT, DONE.
  - Constants `ADDR_W`=13 and `BANK_DEPTH`=4096.
  - Default `WA_W`.
- Sub-module `tiny_dnn_mac`:
  - Holds the delayed-valid flag, `first` handling, `acc`, and the ReLU/`x` register.
  - Ports: `clk`, `rst_n`, `v`, `first`, `d`, `wd`, `load_x`, `relu`, `x`.
- The top level holds the FSM, the counters `i`, `o`, `w`, and the config latches.

## Test plan
- Single MAC: src_size=1, dst_size=1, sbank=1, dbank=0, d=2.0, wd=3.0.
  - `exec`/`ia`=0x1000 at S+1.
  - `outr`/`oa`=0x0000 at S+3.
  - `x`=6.0 at S+4; `done` at S+4.
- 4×2 layer: d={1,2,3,4}; wd at `wa` 0..7 = {1,1,1,1,0.5,0.5,0.5,0.5}.
  - `x`=10.0 at oa=0, then `x`=5.0 at oa=1.
  - `wa` runs 0..7; `done` at S+13.
- ReLU: relu=1 with a dot product of -3.5 → `x`=0.0. The same run with relu=0 → `x`=-3.5.
- Zero size: src_size=0 → `done` at S+1; no `exec` or `outr` ever asserted.
- Busy/start collision:
  - A second `start` mid-run with different sizes and banks is ignored; the outputs match the first config.
  - `start` in the `done` cycle is ignored.
- Reset mid-run: drop `rst_n` during RUN of neuron 1 of 3.
  - All outputs are 0 immediately; no further `outr`.
  - A new `start` then completes normally from `o`=0, `wa`=0.
